// File: rtl/ifu_iccm_arb_ctl_if.sv
// Fetch, DMA and ICCM-port signals of the ICCM arbiter.
// The arbiter uses the slave modport; requesters and the memory use the master modport.
interface ifu_iccm_arb_ctl_if #(
    parameter int ICCM_BITS = 19
);
    logic                   ifc_iccm_req;
    logic [ICCM_BITS-1:2]   ifc_iccm_addr;
    logic                   ifc_iccm_gnt;
    logic                   ifc_iccm_rvalid;
    logic                   dma_iccm_req;
    logic                   dma_iccm_wr;
    logic [ICCM_BITS-1:0]   dma_iccm_addr;
    logic [2:0]             dma_iccm_sz;
    logic [63:0]            dma_iccm_wdata;
    logic                   dma_iccm_gnt;
    logic                   dma_iccm_rvalid;
    logic [63:0]            dma_iccm_rdata;
    logic                   dma_iccm_err;
    logic                   iccm_rden;
    logic                   iccm_wren;
    logic [ICCM_BITS-1:2]   iccm_rw_addr;
    logic [2:0]             iccm_wr_size;
    logic [77:0]            iccm_wr_data;
    logic [155:0]           iccm_rd_data;

    modport slave (
        input  ifc_iccm_req, ifc_iccm_addr, dma_iccm_req, dma_iccm_wr, dma_iccm_addr,
               dma_iccm_sz, dma_iccm_wdata, iccm_rd_data,
        output ifc_iccm_gnt, ifc_iccm_rvalid, dma_iccm_gnt, dma_iccm_rvalid, dma_iccm_rdata,
               dma_iccm_err, iccm_rden, iccm_wren, iccm_rw_addr, iccm_wr_size, iccm_wr_data
    );

    modport master (
        output ifc_iccm_req, ifc_iccm_addr, dma_iccm_req, dma_iccm_wr, dma_iccm_addr,
               dma_iccm_sz, dma_iccm_wdata, iccm_rd_data,
        input  ifc_iccm_gnt, ifc_iccm_rvalid, dma_iccm_gnt, dma_iccm_rvalid, dma_iccm_rdata,
               dma_iccm_err, iccm_rden, iccm_wren, iccm_rw_addr, iccm_wr_size, iccm_wr_data
    );
endinterface

// File: rtl/ifu_iccm_arb_ctl.sv
// ICCM port arbiter: fetch vs DMA with starvation override, ECC packing of DMA
// writes, read-modify-write sequencing for byte/half writes, DMA read steering.
module ifu_iccm_arb_ctl #(
    parameter int ICCM_BITS      = 19,
    parameter int DMA_STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_l,
    ifu_iccm_arb_ctl_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RMW_RD = 2'd1;
    localparam logic [1:0] RMW_WR = 2'd2;
    localparam logic [3:0] STARVE_MAX = 4'(DMA_STARVE_MAX);

    logic [1:0]           r_state;
    logic [3:0]           r_starve_cnt;
    logic [ICCM_BITS-1:0] r_addr;
    logic                 r_half;
    logic [15:0]          r_wdata;
    logic [31:0]          r_merged;
    logic                 r_ifc_rvalid, r_dma_rvalid, r_dma_err, r_rsel;

    logic        w_idle, w_dma_pri, w_ifc_gnt, w_dma_gnt, w_illegal;
    logic        w_dma_rd, w_dma_full_wr, w_dma_rmw, w_rmw_wr;
    logic [2:0]  w_sz;
    logic [ICCM_BITS-1:0] w_addr;
    logic [31:0] w_old, w_merged, w_wd_hi, w_wd_lo;

    function automatic logic [6:0] ecc32(input logic [31:0] d);
        logic [5:0] p;
        p[0] = ^(d & 32'h56AA_AD5B);
        p[1] = ^(d & 32'h9B33_366D);
        p[2] = ^(d & 32'hE3C3_C78E);
        p[3] = ^(d & 32'h03FC_07F0);
        p[4] = ^(d & 32'h03FF_F800);
        p[5] = ^(d & 32'hFC00_0000);
        return {(^d) ^ (^p), p};
    endfunction

    assign w_sz   = bus.dma_iccm_sz;
    assign w_addr = bus.dma_iccm_addr;

    // Gating with rst_l forces every grant/enable low for the whole reset pulse.
    assign w_idle    = rst_l & (r_state == IDLE);
    assign w_rmw_wr  = rst_l & (r_state == RMW_WR);
    assign w_dma_pri = (r_starve_cnt == STARVE_MAX);
    assign w_ifc_gnt = w_idle & bus.ifc_iccm_req & ~(bus.dma_iccm_req & w_dma_pri);
    assign w_dma_gnt = w_idle & bus.dma_iccm_req & (~bus.ifc_iccm_req | w_dma_pri);

    assign w_illegal = w_sz[2]
                     | ((w_sz == 3'd1) & w_addr[0])
                     | ((w_sz == 3'd2) & (|w_addr[1:0]))
                     | ((w_sz == 3'd3) & (|w_addr[2:0]));

    assign w_dma_rd      = w_dma_gnt & ~w_illegal & ~bus.dma_iccm_wr;
    assign w_dma_full_wr = w_dma_gnt & ~w_illegal &  bus.dma_iccm_wr &  w_sz[1];
    assign w_dma_rmw     = w_dma_gnt & ~w_illegal &  bus.dma_iccm_wr & ~w_sz[1];

    always_comb begin
        w_old = '0;
        case (r_addr[3:2])
            2'd0:    w_old = bus.iccm_rd_data[31:0];
            2'd1:    w_old = bus.iccm_rd_data[70:39];
            2'd2:    w_old = bus.iccm_rd_data[109:78];
            default: w_old = bus.iccm_rd_data[148:117];
        endcase
        w_merged = w_old;
        if (r_half) begin
            if (r_addr[1]) w_merged[31:16] = r_wdata;
            else           w_merged[15:0]  = r_wdata;
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // Word writes replicate the word into both halves; the memory picks one by addr[2].
    assign w_wd_lo = w_rmw_wr ? r_merged : bus.dma_iccm_wdata[31:0];
    assign w_wd_hi = w_rmw_wr ? r_merged :
                     (w_sz == 3'd3) ? bus.dma_iccm_wdata[63:32] : bus.dma_iccm_wdata[31:0];

    assign bus.ifc_iccm_gnt    = w_ifc_gnt;
    assign bus.dma_iccm_gnt    = w_dma_gnt;
    assign bus.ifc_iccm_rvalid = r_ifc_rvalid;
    assign bus.dma_iccm_rvalid = r_dma_rvalid;
    assign bus.dma_iccm_err    = r_dma_err;
    assign bus.iccm_rden       = w_ifc_gnt | w_dma_rd | w_dma_rmw;
    assign bus.iccm_wren       = w_dma_full_wr | w_rmw_wr;
    assign bus.iccm_rw_addr    = w_rmw_wr  ? r_addr[ICCM_BITS-1:2] :
                                 w_dma_gnt ? w_addr[ICCM_BITS-1:2] : bus.ifc_iccm_addr;
    assign bus.iccm_wr_size    = w_rmw_wr ? 3'b010 :
                                 w_dma_full_wr ? {1'b0, w_sz[1:0]} : 3'b000;
    assign bus.iccm_wr_data    = {ecc32(w_wd_hi), w_wd_hi, ecc32(w_wd_lo), w_wd_lo};
    assign bus.dma_iccm_rdata  = r_rsel ? {bus.iccm_rd_data[148:117], bus.iccm_rd_data[109:78]}
                                        : {bus.iccm_rd_data[70:39],   bus.iccm_rd_data[31:0]};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_half       <= 1'b0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_ifc_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_dma_err    <= 1'b0;
            r_rsel       <= 1'b0;
        end else begin
            r_ifc_rvalid <= w_ifc_gnt;
            r_dma_rvalid <= w_dma_rd;
            r_dma_err    <= w_dma_gnt & w_illegal;
            if (w_dma_gnt)
                r_starve_cnt <= '0;
            else if (bus.dma_iccm_req && r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 4'd1;
            if (w_dma_gnt)
                r_rsel <= w_addr[3];
            case (r_state)
                IDLE: if (w_dma_rmw) begin
                    r_addr  <= w_addr;
                    r_half  <= w_sz[0];
                    r_wdata <= bus.dma_iccm_wdata[15:0];
                    r_state <= RMW_RD;
                end
                RMW_RD: begin
                    r_merged <= w_merged;
                    r_state  <= RMW_WR;
                end
                RMW_WR:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_iccm_arb_ctl.sv
// Directed bench for ifu_iccm_arb_ctl: vector table plus hand-written RMW,
// starvation and reset sequences.
module tb_ifu_iccm_arb_ctl;
    localparam logic [6:0] IG = 7'b1000000, IR = 7'b0100000, DG = 7'b0010000,
                           DR = 7'b0001000, DE = 7'b0000100, RE = 7'b0000010,
                           WE = 7'b0000001;

    typedef struct {
        logic ir; logic [16:0] ia;
        logic dr; logic dw; logic [18:0] da; logic [2:0] ds; logic [63:0] wd;
        logic [155:0] rd;
        logic [6:0] f; logic [16:0] ea; logic [2:0] es; logic [77:0] ed; logic [63:0] er;
    } vec_t;

    logic clk, rst_l;
    int   checks = 0, errors = 0;
    vec_t tv[17];

    ifu_iccm_arb_ctl_if #(.ICCM_BITS(19)) b();
    ifu_iccm_arb_ctl #(.ICCM_BITS(19), .DMA_STARVE_MAX(7)) dut (
        .clk(clk), .rst_l(rst_l), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hamming SEC-DED built from codeword positions: data fills non-power-of-2 slots 3..38.
    function automatic logic [6:0] ecc(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  e;
        int j;
        cw = '0; e = '0; j = 0;
        for (int p = 1; p <= 38; p++)
            if ((p & (p - 1)) != 0) begin cw[p] = d[j]; j++; end
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                if (((p >> k) & 1) == 1) e[k] = e[k] ^ cw[p];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic logic [38:0] ew(input logic [31:0] w);
        return {ecc(w), w};
    endfunction

    function automatic logic [155:0] line(input logic [31:0] w3, w2, w1, w0);
        return {ew(w3), ew(w2), ew(w1), ew(w0)};
    endfunction

    function automatic logic [77:0] wdup(input logic [31:0] w);
        return {ew(w), ew(w)};
    endfunction

    function automatic vec_t mk(input logic ir, input logic [16:0] ia, input logic dr, input logic dw,
                                input logic [18:0] da, input logic [2:0] ds, input logic [63:0] wd,
                                input logic [155:0] rd, input logic [6:0] f, input logic [16:0] ea,
                                input logic [2:0] es, input logic [77:0] ed, input logic [63:0] er);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.ds = ds; v.wd = wd; v.rd = rd;
        v.f = f; v.ea = ea; v.es = es; v.ed = ed; v.er = er;
        return v;
    endfunction

    function automatic logic [6:0] flg();
        return {b.ifc_iccm_gnt, b.ifc_iccm_rvalid, b.dma_iccm_gnt, b.dma_iccm_rvalid,
                b.dma_iccm_err, b.iccm_rden, b.iccm_wren};
    endfunction

    task automatic chk(input string nm, input logic [155:0] act, input logic [155:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        b.ifc_iccm_req = v.ir; b.ifc_iccm_addr = v.ia;
        b.dma_iccm_req = v.dr; b.dma_iccm_wr = v.dw; b.dma_iccm_addr = v.da;
        b.dma_iccm_sz = v.ds;  b.dma_iccm_wdata = v.wd; b.iccm_rd_data = v.rd;
    endtask

    task automatic idle_in();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_wr(input string nm, input logic [16:0] a, input logic [2:0] s, input logic [77:0] d);
        chk({nm, "_addr"}, 156'(b.iccm_rw_addr), 156'(a));
        chk({nm, "_size"}, 156'(b.iccm_wr_size), 156'(s));
        chk({nm, "_data"}, 156'(b.iccm_wr_data), 156'(d));
    endtask

    localparam logic [31:0] L3 = 32'hCAFEF00D, L2 = 32'h0BADC0DE, L1 = 32'h13572468, L0 = 32'h89ABCDEF;

    initial begin
        logic [155:0] ln;
        ln = line(L3, L2, L1, L0);
        tv[0]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0,  IG|RE,       'h100, 0, 0, 0);
        tv[1]  = mk(1, 'h100, 0, 0, 0, 0, 0, 0,  IG|IR|RE,    'h100, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,      IR,          0, 0, 0, 0);
        tv[3]  = mk(0, 0, 1, 1, 'h08, 3, 64'h11223344_55667788, 0, DG|WE, 'h2, 3,
                    {ew(32'h11223344), ew(32'h55667788)}, 0);
        tv[4]  = mk(0, 0, 1, 0, 'h18, 2, 0, 0,   DG|RE,       'h6, 0, 0, 0);
        tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, ln,     DR,          0, 0, 0, {L3, L2});
        tv[6]  = mk(0, 0, 1, 1, 'h14, 2, 64'hFFFFFFFF_DEADBEEF, 0, DG|WE, 'h5, 2,
                    wdup(32'hDEADBEEF), 0);
        tv[7]  = mk(0, 0, 1, 0, 'h23, 0, 0, 0,   DG|RE,       'h8, 0, 0, 0);
        tv[8]  = mk(1, 'h55, 0, 0, 0, 0, 0, ln,  IG|DR|RE,    'h55, 0, 0, {L1, L0});
        tv[9]  = mk(0, 0, 1, 1, 'h04, 3, 64'h1, 0, IR|DG,     0, 0, 0, 0);
        tv[10] = mk(0, 0, 1, 0, 'h00, 5, 0, 0,   DE|DG,       0, 0, 0, 0);
        tv[11] = mk(0, 0, 1, 1, 'h01, 1, 0, 0,   DE|DG,       0, 0, 0, 0);
        tv[12] = mk(0, 0, 1, 0, 'h02, 2, 0, 0,   DE|DG,       0, 0, 0, 0);
        tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,      DE,          0, 0, 0, 0);
        tv[14] = mk(1, 'h7, 1, 0, 'h30, 3, 0, 0, IG|RE,       'h7, 0, 0, 0);
        tv[15] = mk(0, 0, 1, 0, 'h30, 3, 0, 0,   IR|DG|RE,    'hC, 0, 0, 0);
        tv[16] = mk(0, 0, 0, 0, 0, 0, 0, ln,     DR,          0, 0, 0, {L1, L0});

        // Reset: requests pending but everything must stay quiet.
        rst_l = 1'b0;
        drive(mk(1, 'h100, 1, 0, 'h40, 3, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset_flags", 156'(flg()), 156'(7'd0));
        idle_in();
        @(negedge clk); rst_l = 1'b1;

        for (int i = 0; i < 17; i++) begin
            tick(); drive(tv[i]); #3;
            chk($sformatf("v%0d_flags", i), 156'(flg()), 156'(tv[i].f));
            if (tv[i].f[1] | tv[i].f[0])
                chk($sformatf("v%0d_addr", i), 156'(b.iccm_rw_addr), 156'(tv[i].ea));
            if (tv[i].f[0]) begin
                chk($sformatf("v%0d_wsize", i), 156'(b.iccm_wr_size), 156'(tv[i].es));
                chk($sformatf("v%0d_wdata", i), 156'(b.iccm_wr_data), 156'(tv[i].ed));
            end
            if (tv[i].f[3])
                chk($sformatf("v%0d_rdata", i), 156'(b.dma_iccm_rdata), 156'(tv[i].er));
        end

        // Fetch stream, then asynchronous reset mid-cycle.
        tick(); idle_in(); b.ifc_iccm_req = 1; b.ifc_iccm_addr = 'h100; #3;
        chk("fs_c1", 156'(flg()), 156'(IG|RE));
        tick(); #3;
        chk("fs_c2", 156'(flg()), 156'(IG|IR|RE));
        tick(); rst_l = 1'b0; #1;
        chk("fs_async_rst", 156'(flg()), 156'(7'd0));
        #2; rst_l = 1'b1; #1;
        chk("fs_after_rst", 156'(flg()), 156'(IG|RE));
        tick(); idle_in(); #3;
        chk("idle0", 156'(flg()), 156'(IR));

        // Byte RMW with fetch held off, then back-to-back half RMW.
        tick(); b.dma_iccm_req = 1; b.dma_iccm_wr = 1; b.dma_iccm_addr = 'h0E;
        b.dma_iccm_sz = 0; b.dma_iccm_wdata = 64'h5A; #3;
        chk("rmw_b_c1", 156'(flg()), 156'(DG|RE));
        chk("rmw_b_c1_addr", 156'(b.iccm_rw_addr), 156'(17'h3));
        tick(); b.dma_iccm_req = 0; b.ifc_iccm_req = 1; b.ifc_iccm_addr = 'h33;
        b.iccm_rd_data = line(32'hAABBCCDD, 32'h11111111, 32'h22222222, 32'h33333333); #3;
        chk("rmw_b_c2", 156'(flg()), 156'(7'd0));
        tick(); b.iccm_rd_data = '1; #3;
        chk("rmw_b_c3", 156'(flg()), 156'(WE));
        chk_wr("rmw_b_c3", 'h3, 3'b010, wdup(32'hAA5ACCDD));
        tick(); b.ifc_iccm_req = 0; b.dma_iccm_req = 1; b.dma_iccm_addr = 'h12;
        b.dma_iccm_sz = 1; b.dma_iccm_wdata = 64'hBEEF; #3;
        chk("rmw_h_c1", 156'(flg()), 156'(DG|RE));
        chk("rmw_h_c1_addr", 156'(b.iccm_rw_addr), 156'(17'h4));
        tick(); b.dma_iccm_req = 0; b.ifc_iccm_req = 1;
        b.iccm_rd_data = line(32'h0, 32'h0, 32'h0, 32'h12345678); #3;
        chk("rmw_h_c2", 156'(flg()), 156'(7'd0));
        tick(); b.iccm_rd_data = '0; #3;
        chk("rmw_h_c3", 156'(flg()), 156'(WE));
        chk_wr("rmw_h_c3", 'h4, 3'b010, wdup(32'hBEEF5678));
        tick(); #3;
        chk("rmw_h_c4", 156'(flg()), 156'(IG|RE));
        chk("rmw_h_c4_addr", 156'(b.iccm_rw_addr), 156'(17'h33));

        // Starvation: DMA wins on the 8th cycle, then fetch regains priority.
        tick(); b.dma_iccm_req = 1; b.dma_iccm_wr = 0; b.dma_iccm_addr = 'h40; b.dma_iccm_sz = 3; #3;
        chk("starve_w1", 156'({b.ifc_iccm_gnt, b.dma_iccm_gnt}), 156'(2'b10));
        for (int c = 2; c <= 7; c++) begin
            tick(); #3;
            chk($sformatf("starve_w%0d", c), 156'({b.ifc_iccm_gnt, b.dma_iccm_gnt}), 156'(2'b10));
        end
        tick(); #3;
        chk("starve_win", 156'(flg()), 156'(IR|DG|RE));
        chk("starve_win_addr", 156'(b.iccm_rw_addr), 156'(17'h10));
        tick(); b.dma_iccm_req = 0; #3;
        chk("starve_resume", 156'(flg()), 156'(IG|DR|RE));
        tick(); b.dma_iccm_req = 1; #3;
        chk("starve_cleared", 156'({b.ifc_iccm_gnt, b.dma_iccm_gnt}), 156'(2'b10));
        tick(); idle_in(); #3;
        chk("idle1", 156'(flg()), 156'(IR));

        // Reset during RMW_RD: write abandoned, controller back in IDLE.
        tick(); b.dma_iccm_req = 1; b.dma_iccm_wr = 1; b.dma_iccm_addr = 'h0E;
        b.dma_iccm_sz = 0; b.dma_iccm_wdata = 64'h77; #3;
        chk("rst_rmw_c1", 156'(flg()), 156'(DG|RE));
        tick(); b.dma_iccm_req = 0; b.ifc_iccm_req = 1; rst_l = 1'b0; #1;
        chk("rst_rmw_in_rst", 156'(flg()), 156'(7'd0));
        #2; rst_l = 1'b1; b.ifc_iccm_req = 0; b.dma_iccm_req = 1; b.dma_iccm_wr = 0;
        b.dma_iccm_addr = 'h40; b.dma_iccm_sz = 3; #1;
        chk("rst_rmw_idle", 156'(flg()), 156'(DG|RE));
        tick(); idle_in(); #3;
        chk("rst_rmw_nowr", 156'(flg()), 156'(DR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
